// File: rtl/dec_pkg.sv
// Shared decode definitions: opcodes, ALU operation codes, FSM states and
// the ID/EX register layout used by the decode stage.
package dec_pkg;

  localparam logic [31:0] DEC_NOP    = 32'h0000_0033;
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } dec_state_e;

  typedef struct packed {
    logic        vld;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    alu_op_e     alu_op;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic        reg_write;
    logic        branch;
    logic [2:0]  opsel;
    logic        jal;
    logic        jalr;
    logic        lui;
    logic        auipc;
    logic        halt;
    logic        illegal;
  } idex_t;

  // Bubble: everything cleared, instruction field shows the canonical NOP.
  function automatic idex_t idex_bubble(input logic [31:0] nop);
    idex_t b;
    b      = '0;
    b.inst = nop;
    return b;
  endfunction

  // funct3 to ALU op; alt selects SUB/SRA where funct3 is shared.
  function automatic alu_op_e alu_op_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/dec_stage_imm_gen.sv
// Immediate generator: picks the RV32I immediate format from the opcode and
// sign-extends to 32 bits. Formats without an immediate yield zero.
module imm_gen
  import dec_pkg::*;
(
  input  logic [31:0] inst,
  output logic [31:0] imm
);

  // Format select by opcode
  always_comb begin
    imm = '0;
    case (inst[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR:
        imm = {{20{inst[31]}}, inst[31:20]};
      OPC_STORE:
        imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OPC_BRANCH:
        imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm = {inst[31:12], 12'h000};
      OPC_JAL:
        imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/dec_stage.sv
// RV32I instruction decode stage: register-file addressing, control decode,
// load-use stall detection, sticky halt, and the ID/EX pipeline register.
module dec_stage
  import dec_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter logic [31:0] NOP_INST = DEC_NOP
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [31:0]     i_inst,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_vld,
  input  logic            i_flush,
  input  logic            i_ex_mem_read,
  input  logic [4:0]      i_ex_rd,
  output logic [4:0]      o_rs1_raddr,
  output logic [4:0]      o_rs2_raddr,
  input  logic [XLEN-1:0] i_rs1_rdata,
  input  logic [XLEN-1:0] i_rs2_rdata,
  output logic            o_hold,
  output logic            o_vld,
  output logic [31:0]     o_inst,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_imm,
  output logic [XLEN-1:0] o_rs1_rdata,
  output logic [XLEN-1:0] o_rs2_rdata,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [4:0]      o_rd,
  output logic [3:0]      o_alu_op,
  output logic            o_alu_src,
  output logic            o_mem_read,
  output logic            o_mem_write,
  output logic [2:0]      o_funct3,
  output logic            o_reg_write,
  output logic            o_branch,
  output logic [2:0]      o_opsel,
  output logic            o_jal,
  output logic            o_jalr,
  output logic            o_lui,
  output logic            o_auipc,
  output logic            o_halt,
  output logic            o_illegal
);

  dec_state_e  state_q, state_d;
  idex_t       idex_q, idex_d, dec;
  logic [31:0] imm;
  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic        rs1_used, rs2_used, illegal, wr_en, hazard;

  assign opcode = i_inst[6:0];
  assign rd     = i_inst[11:7];
  assign funct3 = i_inst[14:12];
  assign rs1    = i_inst[19:15];
  assign rs2    = i_inst[24:20];
  assign funct7 = i_inst[31:25];

  assign o_rs1_raddr = rs1;
  assign o_rs2_raddr = rs2;

  imm_gen u_imm_gen (
    .inst (i_inst),
    .imm  (imm)
  );

  // Decode the current IF/ID instruction into a full ID/EX record
  always_comb begin
    dec           = idex_bubble(NOP_INST);
    rs1_used      = 1'b0;
    rs2_used      = 1'b0;
    illegal       = 1'b0;
    wr_en         = 1'b0;
    dec.vld       = 1'b1;
    dec.inst      = i_inst;
    dec.pc        = i_pc;
    dec.imm       = imm;
    dec.rs1_rdata = i_rs1_rdata;
    dec.rs2_rdata = i_rs2_rdata;
    dec.rs1       = rs1;
    dec.rs2       = rs2;
    dec.rd        = rd;
    case (opcode)
      OPC_OP: begin
        rs1_used   = 1'b1;
        rs2_used   = 1'b1;
        wr_en      = 1'b1;
        dec.alu_op = alu_op_from_f3(funct3, i_inst[30]);
        if (!(funct7 == 7'h00 ||
              (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101))))
          illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        rs1_used    = 1'b1;
        wr_en       = 1'b1;
        dec.alu_src = 1'b1;
        // inst[30] only distinguishes SRAI; for ADDI it is an immediate bit
        dec.alu_op  = alu_op_from_f3(funct3, (funct3 == 3'b101) && i_inst[30]);
        if (funct3 == 3'b001 && funct7 != 7'h00)
          illegal = 1'b1;
        if (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20)
          illegal = 1'b1;
      end
      OPC_LOAD: begin
        rs1_used     = 1'b1;
        wr_en        = 1'b1;
        dec.alu_src  = 1'b1;
        dec.mem_read = 1'b1;
        dec.funct3   = funct3;
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)
          illegal = 1'b1;
      end
      OPC_STORE: begin
        rs1_used      = 1'b1;
        rs2_used      = 1'b1;
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.funct3    = funct3;
        if (funct3 > 3'b010)
          illegal = 1'b1;
      end
      OPC_BRANCH: begin
        rs1_used   = 1'b1;
        rs2_used   = 1'b1;
        dec.branch = 1'b1;
        dec.opsel  = funct3;
        dec.alu_op = ALU_SUB;
        if (funct3 == 3'b010 || funct3 == 3'b011)
          illegal = 1'b1;
      end
      OPC_JAL: begin
        wr_en       = 1'b1;
        dec.alu_src = 1'b1;
        dec.jal     = 1'b1;
      end
      OPC_JALR: begin
        rs1_used    = 1'b1;
        wr_en       = 1'b1;
        dec.alu_src = 1'b1;
        dec.jalr    = 1'b1;
        if (funct3 != 3'b000)
          illegal = 1'b1;
      end
      OPC_LUI: begin
        wr_en       = 1'b1;
        dec.alu_src = 1'b1;
        dec.lui     = 1'b1;
      end
      OPC_AUIPC: begin
        wr_en       = 1'b1;
        dec.alu_src = 1'b1;
        dec.auipc   = 1'b1;
      end
      OPC_MISC_MEM: begin
        if (funct3 != 3'b000)
          illegal = 1'b1;
      end
      OPC_SYSTEM: begin
        if (i_inst == INST_ECALL || i_inst == INST_EBREAK)
          dec.halt = 1'b1;
        else
          illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    dec.reg_write = wr_en && (rd != 5'd0);
    // Illegal keeps the data fields for trap reporting but drops every control
    if (illegal) begin
      dec.alu_op    = ALU_ADD;
      dec.alu_src   = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.funct3    = 3'b000;
      dec.reg_write = 1'b0;
      dec.branch    = 1'b0;
      dec.opsel     = 3'b000;
      dec.jal       = 1'b0;
      dec.jalr      = 1'b0;
      dec.lui       = 1'b0;
      dec.auipc     = 1'b0;
      dec.halt      = 1'b0;
      dec.illegal   = 1'b1;
      rs1_used      = 1'b0;
      rs2_used      = 1'b0;
    end
  end

  assign hazard = i_vld && i_ex_mem_read && (i_ex_rd != 5'd0) &&
                  ((rs1_used && rs1 == i_ex_rd) || (rs2_used && rs2 == i_ex_rd));

  // Next state, stall request and ID/EX load selection (flush > hazard > load)
  always_comb begin
    state_d = state_q;
    o_hold  = 1'b0;
    idex_d  = idex_bubble(NOP_INST);
    case (state_q)
      ST_RUN: begin
        if (i_flush) begin
          idex_d = idex_bubble(NOP_INST);
        end else if (hazard) begin
          o_hold = 1'b1;
        end else if (i_vld) begin
          idex_d = dec;
          if (dec.halt || dec.illegal)
            state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        idex_d = idex_bubble(NOP_INST);
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State and ID/EX pipeline register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_RUN;
      idex_q  <= idex_bubble(NOP_INST);
    end else begin
      state_q <= state_d;
      idex_q  <= idex_d;
    end
  end

  assign o_vld       = idex_q.vld;
  assign o_inst      = idex_q.inst;
  assign o_pc        = idex_q.pc;
  assign o_imm       = idex_q.imm;
  assign o_rs1_rdata = idex_q.rs1_rdata;
  assign o_rs2_rdata = idex_q.rs2_rdata;
  assign o_rs1       = idex_q.rs1;
  assign o_rs2       = idex_q.rs2;
  assign o_rd        = idex_q.rd;
  assign o_alu_op    = idex_q.alu_op;
  assign o_alu_src   = idex_q.alu_src;
  assign o_mem_read  = idex_q.mem_read;
  assign o_mem_write = idex_q.mem_write;
  assign o_funct3    = idex_q.funct3;
  assign o_reg_write = idex_q.reg_write;
  assign o_branch    = idex_q.branch;
  assign o_opsel     = idex_q.opsel;
  assign o_jal       = idex_q.jal;
  assign o_jalr      = idex_q.jalr;
  assign o_lui       = idex_q.lui;
  assign o_auipc     = idex_q.auipc;
  assign o_halt      = idex_q.halt;
  assign o_illegal   = idex_q.illegal;

endmodule

// File: tb/tb_dec_stage.sv
// Directed bench for dec_stage: a decode vector table plus hand-written
// sequences for load-use stall, flush priority, halt and reset.
module tb_dec_stage;

  logic        i_clk, i_rst;
  logic [31:0] i_inst, i_pc;
  logic        i_vld, i_flush, i_ex_mem_read;
  logic [4:0]  i_ex_rd;
  logic [4:0]  o_rs1_raddr, o_rs2_raddr;
  logic [31:0] i_rs1_rdata, i_rs2_rdata;
  logic        o_hold, o_vld;
  logic [31:0] o_inst, o_pc, o_imm, o_rs1_rdata, o_rs2_rdata;
  logic [4:0]  o_rs1, o_rs2, o_rd;
  logic [3:0]  o_alu_op;
  logic        o_alu_src, o_mem_read, o_mem_write;
  logic [2:0]  o_funct3, o_opsel;
  logic        o_reg_write, o_branch, o_jal, o_jalr, o_lui, o_auipc, o_halt, o_illegal;

  dec_stage #(.XLEN(32), .NOP_INST(32'h0000_0033)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_inst(i_inst), .i_pc(i_pc), .i_vld(i_vld),
    .i_flush(i_flush), .i_ex_mem_read(i_ex_mem_read), .i_ex_rd(i_ex_rd),
    .o_rs1_raddr(o_rs1_raddr), .o_rs2_raddr(o_rs2_raddr),
    .i_rs1_rdata(i_rs1_rdata), .i_rs2_rdata(i_rs2_rdata), .o_hold(o_hold),
    .o_vld(o_vld), .o_inst(o_inst), .o_pc(o_pc), .o_imm(o_imm),
    .o_rs1_rdata(o_rs1_rdata), .o_rs2_rdata(o_rs2_rdata),
    .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd), .o_alu_op(o_alu_op),
    .o_alu_src(o_alu_src), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_funct3(o_funct3), .o_reg_write(o_reg_write), .o_branch(o_branch),
    .o_opsel(o_opsel), .o_jal(o_jal), .o_jalr(o_jalr), .o_lui(o_lui),
    .o_auipc(o_auipc), .o_halt(o_halt), .o_illegal(o_illegal)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Expected ALU op codes
  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLL = 4'd2,
                         A_SRA = 4'd7, A_AND = 4'd9;

  // Control flag bits: {reg_write, alu_src, mem_read, mem_write, branch,
  //                     jal, jalr, lui, auipc, halt, illegal}
  localparam logic [10:0] F_RW  = 11'b100_0000_0000, F_SRC = 11'b010_0000_0000,
                          F_MR  = 11'b001_0000_0000, F_MW  = 11'b000_1000_0000,
                          F_BR  = 11'b000_0100_0000, F_JAL = 11'b000_0010_0000,
                          F_JR  = 11'b000_0001_0000, F_LUI = 11'b000_0000_1000,
                          F_AUI = 11'b000_0000_0100, F_HLT = 11'b000_0000_0010,
                          F_ILL = 11'b000_0000_0001;
  localparam logic [31:0] NOP = 32'h0000_0033;

  logic [10:0] act_flags;
  assign act_flags = {o_reg_write, o_alu_src, o_mem_read, o_mem_write, o_branch,
                      o_jal, o_jalr, o_lui, o_auipc, o_halt, o_illegal};

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    else
      n_pass++;
  endtask

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic        vld;
    logic        flush;
    logic        e_vld;
    logic [31:0] e_imm;
    logic [4:0]  e_rd;
    logic [3:0]  e_alu;
    logic [10:0] e_flags;
    logic [2:0]  e_f3;
    logic [2:0]  e_opsel;
  } vec_t;

  function automatic vec_t mk(input string n, input logic [31:0] inst, input logic vld,
                              input logic flush, input logic e_vld, input logic [31:0] e_imm,
                              input logic [4:0] e_rd, input logic [3:0] e_alu,
                              input logic [10:0] e_flags, input logic [2:0] e_f3,
                              input logic [2:0] e_opsel);
    vec_t v;
    v.name = n; v.inst = inst; v.vld = vld; v.flush = flush; v.e_vld = e_vld;
    v.e_imm = e_imm; v.e_rd = e_rd; v.e_alu = e_alu; v.e_flags = e_flags;
    v.e_f3 = e_f3; v.e_opsel = e_opsel;
    return v;
  endfunction

  task automatic drive(input logic [31:0] inst, input logic vld, input logic flush,
                       input logic mr, input logic [4:0] exrd);
    i_inst = inst; i_vld = vld; i_flush = flush; i_ex_mem_read = mr; i_ex_rd = exrd;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  vec_t tbl[16];

  initial begin
    tbl[0]  = mk("addi",     32'h0050_0093, 1, 0, 1, 32'h0000_0005, 5'd1,  A_ADD, F_RW|F_SRC,       3'd0, 3'd0);
    tbl[1]  = mk("beq",      32'hFE20_8CE3, 1, 0, 1, 32'hFFFF_FFF8, 5'd25, A_SUB, F_BR,             3'd0, 3'd0);
    tbl[2]  = mk("bge",      32'h0020_D463, 1, 0, 1, 32'h0000_0008, 5'd8,  A_SUB, F_BR,             3'd0, 3'd5);
    tbl[3]  = mk("sub",      32'h4020_81B3, 1, 0, 1, 32'h0000_0000, 5'd3,  A_SUB, F_RW,             3'd0, 3'd0);
    tbl[4]  = mk("srai",     32'h4030_D213, 1, 0, 1, 32'h0000_0403, 5'd4,  A_SRA, F_RW|F_SRC,       3'd0, 3'd0);
    tbl[5]  = mk("sw",       32'h0020_A423, 1, 0, 1, 32'h0000_0008, 5'd8,  A_ADD, F_SRC|F_MW,       3'd2, 3'd0);
    tbl[6]  = mk("lw",       32'hFFC0_A283, 1, 0, 1, 32'hFFFF_FFFC, 5'd5,  A_ADD, F_RW|F_SRC|F_MR,  3'd2, 3'd0);
    tbl[7]  = mk("lui",      32'h1234_52B7, 1, 0, 1, 32'h1234_5000, 5'd5,  A_ADD, F_RW|F_SRC|F_LUI, 3'd0, 3'd0);
    tbl[8]  = mk("jal",      32'h0100_00EF, 1, 0, 1, 32'h0000_0010, 5'd1,  A_ADD, F_RW|F_SRC|F_JAL, 3'd0, 3'd0);
    tbl[9]  = mk("auipc",    32'h0000_1117, 1, 0, 1, 32'h0000_1000, 5'd2,  A_ADD, F_RW|F_SRC|F_AUI, 3'd0, 3'd0);
    tbl[10] = mk("and",      32'h0020_F3B3, 1, 0, 1, 32'h0000_0000, 5'd7,  A_AND, F_RW,             3'd0, 3'd0);
    tbl[11] = mk("fence",    32'h0000_000F, 1, 0, 1, 32'h0000_0000, 5'd0,  A_ADD, 11'd0,            3'd0, 3'd0);
    tbl[12] = mk("addi_x0",  32'h0010_0013, 1, 0, 1, 32'h0000_0001, 5'd0,  A_ADD, F_SRC,            3'd0, 3'd0);
    tbl[13] = mk("novld",    32'h0050_0093, 0, 0, 0, 32'h0000_0000, 5'd0,  A_ADD, 11'd0,            3'd0, 3'd0);
    tbl[14] = mk("flush",    32'h0050_0093, 1, 1, 0, 32'h0000_0000, 5'd0,  A_ADD, 11'd0,            3'd0, 3'd0);
    tbl[15] = mk("jalr",     32'h0041_00E7, 1, 0, 1, 32'h0000_0004, 5'd1,  A_ADD, F_RW|F_SRC|F_JR,  3'd0, 3'd0);

    // Reset state
    i_rst = 1'b1; i_pc = '0; i_rs1_rdata = '0; i_rs2_rdata = '0;
    drive(32'h0050_0093, 1, 0, 0, 5'd0);
    tick(); tick();
    check("rst.vld",   {31'd0, o_vld}, 32'd0);
    check("rst.inst",  o_inst, NOP);
    check("rst.imm",   o_imm, 32'd0);
    check("rst.flags", {21'd0, act_flags}, 32'd0);
    check("rst.pc",    o_pc, 32'd0);
    i_rst = 1'b0;

    // Decode table
    for (int unsigned k = 0; k < 16; k++) begin
      drive(tbl[k].inst, tbl[k].vld, tbl[k].flush, 0, 5'd0);
      i_pc        = 32'h100 + 32'(4 * k);
      i_rs1_rdata = 32'hA000_0000 | 32'(k);
      i_rs2_rdata = 32'hB000_0000 | 32'(k);
      #1;
      check({tbl[k].name, ".hold"}, {31'd0, o_hold}, 32'd0);
      tick();
      check({tbl[k].name, ".vld"},   {31'd0, o_vld}, {31'd0, tbl[k].e_vld});
      check({tbl[k].name, ".inst"},  o_inst, tbl[k].e_vld ? tbl[k].inst : NOP);
      check({tbl[k].name, ".pc"},    o_pc, tbl[k].e_vld ? 32'h100 + 32'(4 * k) : 32'd0);
      check({tbl[k].name, ".imm"},   o_imm, tbl[k].e_imm);
      check({tbl[k].name, ".rd"},    {27'd0, o_rd}, {27'd0, tbl[k].e_rd});
      check({tbl[k].name, ".alu"},   {28'd0, o_alu_op}, {28'd0, tbl[k].e_alu});
      check({tbl[k].name, ".flags"}, {21'd0, act_flags}, {21'd0, tbl[k].e_flags});
      check({tbl[k].name, ".f3"},    {29'd0, o_funct3}, {29'd0, tbl[k].e_f3});
      check({tbl[k].name, ".opsel"}, {29'd0, o_opsel}, {29'd0, tbl[k].e_opsel});
      check({tbl[k].name, ".rs1d"},  o_rs1_rdata, tbl[k].e_vld ? (32'hA000_0000 | 32'(k)) : 32'd0);
      check({tbl[k].name, ".rs2d"},  o_rs2_rdata, tbl[k].e_vld ? (32'hB000_0000 | 32'(k)) : 32'd0);
    end

    // Regfile read addresses are combinational
    drive(32'hFE20_8CE3, 1, 0, 0, 5'd0); #1;
    check("beq.raddr1", {27'd0, o_rs1_raddr}, 32'd1);
    check("beq.raddr2", {27'd0, o_rs2_raddr}, 32'd2);

    // Load-use on rs1: stall, bubble, then issue
    drive(32'h0072_8333, 1, 0, 1, 5'd5); i_pc = 32'h200; #1;
    check("lu.hold", {31'd0, o_hold}, 32'd1);
    tick();
    check("lu.bubble_vld",  {31'd0, o_vld}, 32'd0);
    check("lu.bubble_inst", o_inst, NOP);
    i_ex_mem_read = 1'b0; #1;
    check("lu.release", {31'd0, o_hold}, 32'd0);
    tick();
    check("lu.issue_vld", {31'd0, o_vld}, 32'd1);
    check("lu.issue_rd",  {27'd0, o_rd}, 32'd6);
    check("lu.issue_pc",  o_pc, 32'h200);
    // rs2 match, then x0 destination, then unused-source formats
    drive(32'h0072_8333, 1, 0, 1, 5'd7); #1;
    check("lu.rs2_hold", {31'd0, o_hold}, 32'd1);
    drive(32'h0000_8033, 1, 0, 1, 5'd0); #1;
    check("lu.x0_nohold", {31'd0, o_hold}, 32'd0);
    drive(32'h0002_A0B7, 1, 0, 1, 5'd5); #1;
    check("lu.lui_nohold", {31'd0, o_hold}, 32'd0);
    drive(32'h0050_0093, 1, 0, 1, 5'd5); #1;
    check("lu.addi_rs2field_nohold", {31'd0, o_hold}, 32'd0);
    drive(32'h0072_8333, 0, 0, 1, 5'd5); #1;
    check("lu.novld_nohold", {31'd0, o_hold}, 32'd0);

    // Hazard together with flush: flush wins
    drive(32'h0072_8333, 1, 1, 1, 5'd5); #1;
    check("hf.hold", {31'd0, o_hold}, 32'd0);
    tick();
    check("hf.vld",  {31'd0, o_vld}, 32'd0);
    check("hf.inst", o_inst, NOP);

    // ECALL under flush is discarded; no halt follows
    drive(32'h0000_0073, 1, 1, 0, 5'd0); tick();
    check("ecf.vld",  {31'd0, o_vld}, 32'd0);
    check("ecf.halt", {31'd0, o_halt}, 32'd0);
    drive(32'h0050_0093, 1, 0, 0, 5'd0); tick();
    check("ecf.next_vld", {31'd0, o_vld}, 32'd1);

    // EBREAK halts; subsequent instructions are bubbled, no stalls
    drive(32'h0010_0073, 1, 0, 0, 5'd0); tick();
    check("ebk.halt", {31'd0, o_halt}, 32'd1);
    check("ebk.vld",  {31'd0, o_vld}, 32'd1);
    check("ebk.rw",   {31'd0, o_reg_write}, 32'd0);
    drive(32'h0050_0093, 1, 0, 0, 5'd0);
    for (int unsigned c = 0; c < 3; c++) begin
      tick();
      check("halt.vld", {31'd0, o_vld}, 32'd0);
    end
    drive(32'h0072_8333, 1, 0, 1, 5'd5); #1;
    check("halt.nohold", {31'd0, o_hold}, 32'd0);
    // Reset leaves HALT
    i_rst = 1'b1; tick();
    check("halt.rst_vld",  {31'd0, o_vld}, 32'd0);
    check("halt.rst_halt", {31'd0, o_halt}, 32'd0);
    i_rst = 1'b0;
    drive(32'h0050_0093, 1, 0, 0, 5'd0); tick();
    check("post_rst.vld", {31'd0, o_vld}, 32'd1);
    check("post_rst.imm", o_imm, 32'd5);

    // Illegal opcode
    drive(32'hFFFF_FFFF, 1, 0, 0, 5'd0); tick();
    check("ill.vld",   {31'd0, o_vld}, 32'd1);
    check("ill.flags", {21'd0, act_flags}, {21'd0, F_ILL});
    drive(32'h0050_0093, 1, 0, 0, 5'd0); tick();
    check("ill.halted", {31'd0, o_vld}, 32'd0);
    i_rst = 1'b1; tick(); i_rst = 1'b0;

    // Illegal funct7 on R-type (M-extension encoding)
    drive(32'h0220_8033, 1, 0, 0, 5'd0); tick();
    check("ill7.flags", {21'd0, act_flags}, {21'd0, F_ILL});
    i_rst = 1'b1; tick(); i_rst = 1'b0;

    // Reserved SRLI/SRAI funct7 and invalid branch funct3
    drive(32'h0030_D213 | 32'h0200_0000, 1, 0, 0, 5'd0); tick();
    check("illsh.flags", {21'd0, act_flags}, {21'd0, F_ILL});
    i_rst = 1'b1; tick(); i_rst = 1'b0;
    drive(32'h0020_A463, 1, 0, 0, 5'd0); tick();
    check("illbr.flags", {21'd0, act_flags}, {21'd0, F_ILL});
    i_rst = 1'b1; tick(); i_rst = 1'b0;

    // SLL after recovery
    drive(32'h0020_91B3, 1, 0, 0, 5'd0); tick();
    check("sll.alu", {28'd0, o_alu_op}, {28'd0, A_SLL});
    check("sll.rw",  {31'd0, o_reg_write}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dec_stage.md
Name: dec_stage

Overview:
Instruction decode stage of the 5-stage RV32I pipeline. It sits directly downstream of the fetch stage and consumes its IF/ID outputs: instruction, PC and valid. It decodes the instruction, drives register-file read addresses, generates the immediate and control bundle, detects load-use hazards (hold back to fetch), and owns the ID/EX pipeline register. Sticky halt on ECALL/EBREAK/illegal.

Parameters:
XLEN, 32, datapath width (only 32 supported)
NOP_INST, 32'h00000033, canonical bubble encoding (add x0,x0,x0) reported on o_inst when bubbled

Ports:
i_clk  in  1  global clock
i_rst  in  1  synchronous active-high reset
i_inst  in  32  instruction from IF/ID
i_pc  in  32  PC of i_inst
i_vld  in  1  IF/ID valid
i_flush  in  1  branch/jump redirect from EX; kill ID contents
i_ex_mem_read  in  1  instruction now in EX is a load
i_ex_rd  in  5  destination of instruction now in EX
o_rs1_raddr  out  5  regfile read addr 1 (combinational, i_inst[19:15])
o_rs2_raddr  out  5  regfile read addr 2 (combinational, i_inst[24:20])
i_rs1_rdata  in  32  regfile read data 1 (same cycle)
i_rs2_rdata  in  32  regfile read data 2 (same cycle)
o_hold  out  1  combinational stall request to fetch (load-use)
o_vld, o_inst[32], o_pc[32], o_imm[32], o_rs1_rdata[32], o_rs2_rdata[32], o_rs1[5], o_rs2[5], o_rd[5]  out  registered ID/EX fields
o_alu_op[4], o_alu_src, o_mem_read, o_mem_write, o_funct3[3], o_reg_write, o_branch, o_opsel[3], o_jal, o_jalr, o_lui, o_auipc, o_halt, o_illegal  out  registered ID/EX control

Behaviour:
- Latency: 1 cycle from i_inst to ID/EX outputs. Regfile read is combinational in the same cycle.
- Reset: FSM=RUN, o_vld=0, o_inst=NOP_INST, every other output register=0.
- Immediate formats: I, S, B, U, J, sign-extended to 32 bits. B/J carry bit0=0. U = inst[31:12]<<12. R-type imm=0.
- o_reg_write is forced to 0 when rd=0, and for S/B/illegal/system instructions.
- o_opsel = funct3 for branches. o_funct3 = funct3 for loads/stores.
- o_alu_op encoding comes from the package: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND. SUB/SRA are selected by inst[30] on R-type; SRAI is selected by inst[30] on I-type shifts.
- Illegal: opcode not in the RV32I set, or an invalid funct3/funct7 combination. Result: o_illegal=1, o_vld=1, all side-effect controls=0.
- Load-use hazard: hazard = i_vld & i_ex_mem_read & i_ex_rd!=0 & ((rs1 used & rs1==i_ex_rd) | (rs2 used & rs2==i_ex_rd)).
  - "Used" follows the format: U/J use neither; I/load/jalr use rs1 only; R/S/B use both.
- o_hold = hazard & ~i_flush & state==RUN.
- While o_hold=1, ID/EX loads a bubble (o_vld=0, all controls 0, o_inst=NOP_INST). Fetch keeps i_inst stable and it is re-decoded next cycle.
- Flush priority: i_flush beats hazard beats normal load. Flush loads a bubble; FSM unchanged.
- i_vld=0 loads a bubble.
- FSM RUN: a valid, non-flushed ECALL (0x00000073), EBREAK (0x00100073) or illegal instruction is loaded into ID/EX with o_halt=1 (or o_illegal=1) and the FSM moves to HALT.
- FSM HALT: every subsequent cycle loads a bubble and o_hold=0. Exit only via i_rst.
- Flush in the same cycle as ECALL: the flush wins, there is no transition, and the ECALL is discarded.
- Reset mid-operation (any state, including HALT) returns to RUN with reset outputs on the next edge.
- FENCE decodes as a valid NOP (no controls asserted).

Decomposition:
- Package dec_pkg: opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, MISC_MEM), ALU op enum, FSM state typedef (RUN, HALT), NOP constant.
- Sub-module imm_gen: combinational, inputs inst[31:0], output imm[31:0], with the format chosen by opcode.

Test Plan:
- addi x1,x0,5 (0x00500093), pc 0x100, i_vld=1 -> next cycle o_vld=1, o_pc=0x100, o_imm=5, o_rd=1, o_alu_src=1, o_alu_op=ADD, o_reg_write=1.
- beq x1,x2,-8 (0xFE208CE3) -> o_imm=0xFFFFFFF8, o_branch=1, o_opsel=0, o_reg_write=0, o_rs1_raddr=1, o_rs2_raddr=2.
- Load-use: i_ex_mem_read=1, i_ex_rd=5, i_inst=add x6,x5,x7 (0x00728333) -> o_hold=1 same cycle, next o_vld=0. Drop i_ex_mem_read -> o_hold=0, add issues with o_rd=6. Repeat with lui x5 (rs unused) -> no hold.
- Hazard and i_flush together -> o_hold=0, next o_vld=0, o_inst=0x00000033.
- EBREAK (0x00100073) -> next o_halt=1, o_vld=1. Following addi inputs -> o_vld=0 indefinitely. Pulse i_rst -> RUN, next addi decodes normally.
- Illegal 0xFFFFFFFF -> o_illegal=1, o_reg_write=0, o_mem_write=0, FSM=HALT. addi x0,x0,1 -> o_reg_write=0 (rd=0 suppression).
